// File: rtl/ascon_pack.sv
// Shared ASCON control constants and the permutation round sequencer state type.
package ascon_pack;

    localparam int          ROUNDS_PA  = 12;
    localparam int          ROUNDS_PB  = 6;
    localparam logic [3:0]  LAST_ROUND = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } type_perm_ctrl_state;

endpackage

// File: rtl/permutation_round_ctrl.sv
// Round sequencer for the ASCON permutation datapath: issues p^a or p^b as sel/en/round.
// Optional macro ASCON_PERM_STALL_EN adds stall_i, which freezes a run in FIRST/RUN.
module permutation_round_ctrl
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = ROUNDS_PA,
    parameter int ROUNDS_B = ROUNDS_PB
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
`ifdef ASCON_PERM_STALL_EN
    input  logic       stall_i,
`endif
    output logic       sel_o,
    output logic       en_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

    if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
        $error("permutation_round_ctrl: ROUNDS_A must be in 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
        $error("permutation_round_ctrl: ROUNDS_B must be in 1..12");
    end

    type_perm_ctrl_state state;
    logic [3:0]          round_q;
    logic                sel_q;
    logic                en_q;
    logic                busy_q;
    logic                done_q;
    logic                hold;

`ifdef ASCON_PERM_STALL_EN
    assign hold = stall_i;
`else
    assign hold = 1'b0;
`endif

    // IDLE and DONE both accept a start, so back-to-back runs leave no idle gap.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state   <= IDLE;
            round_q <= 4'd0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    sel_q  <= 1'b0;
                    if (start_i) begin
                        state   <= FIRST;
                        round_q <= mode_i ? START_B : START_A;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        round_q <= 4'd0;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                FIRST, RUN: begin
                    if (!hold) begin
                        sel_q <= 1'b1;
                        if (round_q == LAST_ROUND) begin
                            state  <= DONE;
                            en_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= RUN;
                            round_q <= round_q + 4'd1;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled cycle must not clock the datapath; en_q stays set so the run resumes.
    assign en_o    = en_q & ~hold;
    assign sel_o   = sel_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Bench for permutation_round_ctrl: default instance plus a ROUNDS_A=1/ROUNDS_B=3 instance.
module tb_permutation_round_ctrl;

    localparam int RA0 = 12, RB0 = 6;
    localparam int RA1 = 1,  RB1 = 3;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic start0 = 1'b0, mode0 = 1'b0;
    logic start1 = 1'b0, mode1 = 1'b0;

    logic       sel0, en0, busy0, done0;
    logic [3:0] round0;
    logic       sel1, en1, busy1, done1;
    logic [3:0] round1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    permutation_round_ctrl dut (
        .clock_i (clk),
        .resetb_i(resetb),
        .start_i (start0),
        .mode_i  (mode0),
        .sel_o   (sel0),
        .en_o    (en0),
        .round_o (round0),
        .busy_o  (busy0),
        .done_o  (done0)
    );

    permutation_round_ctrl #(.ROUNDS_A(RA1), .ROUNDS_B(RB1)) dut1 (
        .clock_i (clk),
        .resetb_i(resetb),
        .start_i (start1),
        .mode_i  (mode1),
        .sel_o   (sel1),
        .en_o    (en1),
        .round_o (round1),
        .busy_o  (busy1),
        .done_o  (done1)
    );

    // Output tuple: {sel, en, busy, done, round[3:0]}
    function automatic logic [7:0] entry(int i, int n);
        if (i == n) return {1'b1, 1'b0, 1'b0, 1'b1, 4'd11};
        return {(i != 0), 1'b1, 1'b1, 1'b0, 4'(12 - n + i)};
    endfunction

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // Reference: an accepted start schedules N round cycles plus one DONE cycle.
    always @(posedge clk) begin
        if (resetb) begin
            automatic bit acc0 = start0 && (q0.size() == 0 || q0[0][4]);
            automatic bit acc1 = start1 && (q1.size() == 0 || q1[0][4]);
            automatic int n;
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
            if (acc0) begin
                n = mode0 ? RB0 : RA0;
                for (int i = 0; i <= n; i++) q0.push_back(entry(i, n));
            end
            if (acc1) begin
                n = mode1 ? RB1 : RA1;
                for (int i = 0; i <= n; i++) q1.push_back(entry(i, n));
            end
        end
    end

    always @(negedge resetb) begin
        q0.delete();
        q1.delete();
    end

    always @(negedge clk) begin
        automatic logic [7:0] e0 = (q0.size() != 0) ? q0[0] : 8'h00;
        automatic logic [7:0] e1 = (q1.size() != 0) ? q1[0] : 8'h00;
        automatic logic [7:0] g0 = {sel0, en0, busy0, done0, round0};
        automatic logic [7:0] g1 = {sel1, en1, busy1, done1, round1};
        tests++;
        if (g0 !== e0) begin
            fails++;
            $display("FAIL model_dut0 t=%0t got=%b exp=%b", $time, g0, e0);
        end
        tests++;
        if (g1 !== e1) begin
            fails++;
            $display("FAIL model_dut1 t=%0t got=%b exp=%b", $time, g1, e1);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    initial begin
        #3;
        chk("reset_dut0", {sel0, en0, busy0, done0, round0}, 8'h00);
        chk("reset_dut1", {sel1, en1, busy1, done1, round1}, 8'h00);
        @(negedge clk); #2 resetb = 1'b1;

        // p^a: round 0 with sel=0, then 1..11 with sel=1, done at k+13
        @(negedge clk); start0 = 1'b1; mode0 = 1'b0;
        @(negedge clk); start0 = 1'b0;
        chk("pa_first", {sel0, en0, busy0, done0, round0}, 8'b0110_0000);
        for (int r = 1; r <= 11; r++) begin
            @(negedge clk);
            chk("pa_run", {sel0, en0, busy0, done0, round0}, {4'b1110, 4'(r)});
        end
        @(negedge clk);
        chk("pa_done", {sel0, en0, busy0, done0, round0}, 8'b1001_1011);
        @(negedge clk);
        chk("pa_idle", {sel0, en0, busy0, done0, round0}, 8'h00);

        // p^b with start held: ignored while busy, re-accepted in DONE
        start0 = 1'b1; mode0 = 1'b1;
        @(negedge clk);
        chk("pb_first", {sel0, en0, busy0, done0, round0}, 8'b0110_0110);
        for (int r = 7; r <= 11; r++) begin
            @(negedge clk);
            chk("pb_run", {sel0, en0, busy0, done0, round0}, {4'b1110, 4'(r)});
        end
        @(negedge clk);
        chk("pb_done", {sel0, en0, busy0, done0, round0}, 8'b1001_1011);
        @(negedge clk);
        start0 = 1'b0;
        chk("pb_b2b_first", {sel0, en0, busy0, done0, round0}, 8'b0110_0110);
        repeat (8) @(negedge clk);
        chk("pb_b2b_idle", {sel0, en0, busy0, done0, round0}, 8'h00);

        // Asynchronous reset at round 4 of a p^a run
        start0 = 1'b1; mode0 = 1'b0;
        @(negedge clk); start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_at_round4", {sel0, en0, busy0, done0, round0}, 8'b1110_0100);
        #2 resetb = 1'b0;
        #1 chk("rst_async", {sel0, en0, busy0, done0, round0}, 8'h00);
        @(negedge clk);
        chk("rst_no_done", {sel0, en0, busy0, done0, round0}, 8'h00);
        #2 resetb = 1'b1;
        @(negedge clk); start0 = 1'b1; mode0 = 1'b0;
        @(negedge clk); start0 = 1'b0;
        chk("rst_restart", {sel0, en0, busy0, done0, round0}, 8'b0110_0000);
        repeat (12) @(negedge clk);
        chk("rst_restart_done", {sel0, en0, busy0, done0, round0}, 8'b1001_1011);

        // ROUNDS_A=1: FIRST at round 11, done next cycle
        @(negedge clk); start1 = 1'b1; mode1 = 1'b0;
        @(negedge clk); start1 = 1'b0;
        chk("r1_first", {sel1, en1, busy1, done1, round1}, 8'b0110_1011);
        @(negedge clk);
        chk("r1_done", {sel1, en1, busy1, done1, round1}, 8'b1001_1011);
        @(negedge clk);
        chk("r1_idle", {sel1, en1, busy1, done1, round1}, 8'h00);

        // Randomized traffic on both instances, checked by the reference
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start0 = ($urandom_range(0, 3) == 0);
            mode0  = $urandom_range(0, 1);
            start1 = ($urandom_range(0, 2) == 0);
            mode1  = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) begin
                #2 resetb = 1'b0;
                @(negedge clk);
                #2 resetb = 1'b1;
            end
        end
        @(negedge clk); start0 = 1'b0; start1 = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/permutation_round_ctrl.md
Name: permutation_round_ctrl

Overview:
- Sequencer that drives the control side of the ASCON round datapath (permutation_step_1): sel, en and round index.
- On a start request it issues either p^a (12 rounds) or p^b (6 rounds).
- Round 0 of a run selects the external state (sel=0). Later rounds select the feedback register (sel=1).
- Sits between the top-level ASCON FSM and the permutation datapath.

Parameters:
- ROUNDS_A, 12, number of rounds for p^a; round index starts at 12-ROUNDS_A.
- ROUNDS_B, 6, number of rounds for p^b; round index starts at 12-ROUNDS_B.
- Both must be 1..12. This is checked with an elaboration-time assertion.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request, sampled on the rising edge.
- mode_i  in  1  0 = p^a (ROUNDS_A), 1 = p^b (ROUNDS_B); sampled with start_i.
- sel_o  out  1  datapath input select: 0 = external state_i, 1 = feedback.
- en_o  out  1  datapath register enable.
- round_o  out  4  round-constant index, 0..11.
- busy_o  out  1  high while rounds are being issued.
- done_o  out  1  one-cycle pulse after the final round.
- stall_i  in  1  present only with ASCON_PERM_STALL_EN.

Behaviour:
- Reset values (asynchronous, resetb_i=0): state IDLE; sel_o=0, en_o=0, round_o=0, busy_o=0, done_o=0.
- Outputs are Moore-decoded from the state register and the round register. They are glitch-free registered values, with no combinational path from start_i.
- FSM states: IDLE, FIRST, RUN, DONE.
- IDLE: all outputs 0.
  - start_i=1: latch mode_i.
  - Load round register with 12-ROUNDS_A (mode 0) or 12-ROUNDS_B (mode 1).
  - Go to FIRST.
- FIRST: sel_o=0, en_o=1, busy_o=1, round_o = start index.
  - Start index = 11: go to DONE.
  - Otherwise: increment round, go to RUN.
- RUN: sel_o=1, en_o=1, busy_o=1.
  - round_o = 11: go to DONE.
  - Otherwise: increment round, stay in RUN.
- DONE: done_o=1, en_o=0, busy_o=0, sel_o=1, round_o holds 11.
  - start_i=1: accepted back-to-back, reload, go to FIRST.
  - Otherwise: go to IDLE; round_o returns to 0.
- Latency: start sampled at edge k.
  - en_o is high for exactly N cycles, starting at cycle k+1.
  - done_o is high in cycle k+N+1.
  - Next start is accepted at the edge ending the DONE cycle, so there is no idle gap.
- start_i while in FIRST or RUN is ignored, with no queueing.
- mode_i is only sampled with an accepted start.
- Round arithmetic is 4-bit unsigned and never exceeds 11; wrap-around is impossible by construction.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, no done_o pulse.

Optional Feature:
- Macro: ASCON_PERM_STALL_EN.
- With the macro defined, port stall_i exists. While stall_i=1 in FIRST or RUN:
  - en_o=0;
  - round and state hold;
  - sel_o holds its value.
  - Rounds issued still total N. done_o is delayed by the number of stalled cycles.
  - stall_i is ignored in IDLE and DONE.
- Without the macro: no stall_i port; behaviour as above.

Decomposition:
- Add to ascon_pack:
  - localparam ROUNDS_PA=12;
  - localparam ROUNDS_PB=6;
  - localparam LAST_ROUND=4'd11;
  - enum type_perm_ctrl_state {IDLE, FIRST, RUN, DONE}, 2-bit.
- Single flat module. The counter plus FSM is too small to justify a sub-module.
- Integration wrapper (not part of this block) connects sel_o/en_o/round_o to permutation_step_1.

Test Plan:
1. Reset, then start_i=1, mode_i=0 for one cycle -> sel_o=0 with round_o=0 for one cycle, then sel_o=1 with round_o=1..11 on consecutive cycles; en_o high 12 cycles; done_o pulse at cycle 13; busy_o low after.
2. start_i=1, mode_i=1 -> round_o sequence 6,7,8,9,10,11; sel_o=0 only at 6; en_o high 6 cycles; done_o one cycle later.
3. start_i held high through a p^b run -> ignored while busy; re-accepted in the DONE cycle; second run begins with FIRST, round_o=6, with no idle cycle.
4. Assert resetb_i=0 asynchronously while round_o=4 in a p^a run -> all outputs 0 immediately; no done_o; a new start runs a full 12 rounds from 0.
5. ROUNDS_A=1 override, mode_i=0 -> FIRST with round_o=11 for one cycle, sel_o=0; done_o the next cycle.
6. With ASCON_PERM_STALL_EN: p^a run with stall_i=1 for 3 cycles at round_o=5 -> en_o low 3 cycles; round_o holds 5; done_o at cycle 16 after start.
